elevator_call_scheduler: RTL and testbench
==========================================

ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 DWELL_CYCLES, 2000, door-open dwell length in clock cycles (range 1..2^21-1).
REQ-003 clk10000hz  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-005 hall_up_req  input  3  hall "up" buttons, bit i = floor i+1 (floors 1..3), sampled every cycle.
REQ-006 hall_dn_req  input  3  hall "down" buttons, bit i = floor i+2 (floors 2..4), sampled every cycle.
REQ-007 car_req  input  4  in-car buttons, bit i = floor i+1, sampled every cycle.
REQ-008 move_valid  output  1  a one-floor step is requested.
REQ-009 move_up  output  1  step direction: 1 = up, 0 = down; valid while move_valid = 1.
REQ-010 move_ready  input  1  the motion unit accepts the step.
REQ-011 step_done  input  1  single-cycle pulse: the accepted step has finished.
REQ-012 floor  output  2  current floor, 0..3 = floors 1..4.
REQ-013 dir  output  2  00 = idle, 01 = up, 10 = down; 11 is never driven.
REQ-014 door_open  output  1  high only in DWELL.
REQ-015 hall_up_lamp / hall_dn_lamp / car_lamp  output  3/3/4  pending-request bits, same indexing as the request inputs.

Function
REQ-016 The state machine SHALL have four states: IDLE, DWELL, MOVE_REQ and MOVING.
REQ-017 A request input bit SHALL set its lamp bit on the next edge, except when the request is at the current floor in DWELL and is either a car request or a hall request matching dir (or dir = idle); in that case the bit stays clear and the dwell counter reloads to 0.
REQ-018 Entering DWELL at floor f SHALL clear car_lamp[f] and the hall lamp of f for the current dir, or both hall lamps of f if dir = idle or a reversal happens at f.
REQ-019 On the same edge as REQ-018, a clear SHALL win over a set for floor f only; sets for other floors are unaffected.
REQ-020 "ahead" = any lamp bit at a floor strictly beyond floor in dir; "behind" = any lamp bit at a floor strictly on the opposite side.
REQ-021 In IDLE with a pending lamp at floor, the block SHALL go to DWELL on the next edge.
REQ-022 In IDLE otherwise: any lamp above sets dir = up and goes to MOVE_REQ; else any lamp below sets dir = down and goes to MOVE_REQ; up wins when lamps exist both above and below.
REQ-023 In MOVE_REQ, move_valid SHALL be 1 and move_up = (dir == up); the block moves to MOVING on the edge where move_ready = 1.
REQ-024 In MOVING, step_done SHALL change floor by ±1 on the same edge.
REQ-025 After a step, the block SHALL stop (go to DWELL) if, at the new floor: car_lamp is set, or the hall lamp for dir is set, or nothing is ahead and any hall lamp is set (the reversal case; dir flips).
REQ-026 After a step, if none of the REQ-025 conditions hold, the block SHALL go to MOVE_REQ.
REQ-027 DWELL SHALL last DWELL_CYCLES cycles.
REQ-028 At the end of DWELL: if anything is ahead, go to MOVE_REQ; else if anything is behind, flip dir and go to MOVE_REQ; else set dir = idle and go to IDLE.
REQ-029 Boundary: the block SHALL never request up at floor 3 (floor 4) or down at floor 0 (floor 1); dir is forced to reverse or go idle at the end floors.
REQ-030 step_done outside MOVING and move_ready outside MOVE_REQ SHALL be ignored.
REQ-031 Dwell latency: door_open SHALL rise on the edge after the deciding step_done or IDLE decision.

Reset
REQ-032 While reset = 0, the outputs SHALL be: floor = 0, dir = 00, door_open = 0, move_valid = 0, move_up = 0, all lamps 0, state = IDLE, dwell counter = 0; this holds even if reset is asserted mid-move.
REQ-033 After reset release, the first action SHALL occur on the first rising edge of clk10000hz.

Structure
REQ-034 A shared package elevator_pkg SHALL hold the floor count (4), the dir encodings, the state enumeration and the DWELL_CYCLES default.
REQ-035 The request register bank (set/clear/lamp logic) SHALL be one sub-module, elevator_call_latch; sequencing stays in the top module.

Verification
REQ-036 Reset, then car_req = 4'b1000 for 1 cycle -> dir = 01; 3 handshakes; floor = 3; door_open for 2000 cycles; then dir = 00, car_lamp = 0.
REQ-037 At floor 0 moving up, hall_dn_req[0] (floor 2) and car_req[3] -> passes floor 1 without stopping, stops at floor 3, reverses, stops at floor 1 and clears hall_dn_lamp[0].
REQ-038 In DWELL at floor 1 with dir = up, pulse hall_up_req[1] at cycle 1500 -> lamp stays 0; door_open lasts 1500 + 2000 cycles total.
REQ-039 move_ready held 0 for 50 cycles in MOVE_REQ -> move_valid stays 1 and floor stays unchanged; a step_done injected meanwhile is ignored.
REQ-040 Assert reset during MOVING at floor 2 with lamps pending -> all outputs match REQ-032 while reset is low; after release, the block stays IDLE.
REQ-041 From IDLE at floor 1, lamps set at floor 0 and floor 3 on the same edge -> dir = up first; floor 3 is served, then floor 0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared constants, direction encodings and state enumeration for the
// four-floor elevator call scheduler.
package elevator_pkg;

  localparam int NUM_FLOORS       = 4;
  localparam int FLOOR_W          = 2;
  localparam int DWELL_CYCLES_DEF = 2000;
  localparam int DWELL_CNT_W      = 21;

  typedef logic [1:0] dir_t;
  localparam dir_t DIR_IDLE = 2'b00;
  localparam dir_t DIR_UP   = 2'b01;
  localparam dir_t DIR_DN   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_MOVE_REQ,
    S_MOVING
  } state_t;

  // Floors strictly above f.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] base;
    base = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
    return base << f;
  endfunction

  // Floors strictly below f.
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] one;
    one = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
    return (one << f) - one;
  endfunction

endpackage

// File: rtl/elevator_call_latch.sv
// Pending-request register bank: latches hall/car buttons into lamps, absorbs
// requests answered by the open door, and clears the floor being served.
module elevator_call_latch
  import elevator_pkg::*;
(
  input  logic               clk10000hz,
  input  logic               reset,
  input  logic [2:0]         i_hall_up_req,
  input  logic [2:0]         i_hall_dn_req,
  input  logic [3:0]         i_car_req,
  input  logic [FLOOR_W-1:0] i_floor,
  input  dir_t               i_dir,
  input  logic               i_in_dwell,
  input  logic               i_clr_en,
  input  logic [FLOOR_W-1:0] i_clr_floor,
  input  logic               i_clr_up,
  input  logic               i_clr_dn,
  output logic [2:0]         o_hall_up_lamp,
  output logic [2:0]         o_hall_dn_lamp,
  output logic [3:0]         o_car_lamp,
  output logic               o_absorb
);

  logic [2:0]            r_hall_up, r_hall_dn;
  logic [3:0]            r_car;
  logic [2:0]            w_hall_up_next, w_hall_dn_next, w_up_hit, w_dn_hit;
  logic [3:0]            w_car_next, w_car_hit;
  logic [NUM_FLOORS-1:0] w_at_floor, w_clr_sel;

  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      assign w_at_floor[gi] = i_in_dwell && (i_floor == FLOOR_W'(gi));
      assign w_clr_sel[gi]  = i_clr_en && (i_clr_floor == FLOOR_W'(gi));
      assign w_car_hit[gi]  = i_car_req[gi] && w_at_floor[gi];
      assign w_car_next[gi] = (r_car[gi] || (i_car_req[gi] && !w_at_floor[gi])) && !w_clr_sel[gi];
    end

    // Hall up bit gi sits at floor gi, hall down bit gi at floor gi+1.
    for (genvar gi = 0; gi < NUM_FLOORS-1; gi++) begin : g_hall
      logic w_up_sup, w_dn_sup;
      assign w_up_sup           = w_at_floor[gi]   && (i_dir != DIR_DN);
      assign w_dn_sup           = w_at_floor[gi+1] && (i_dir != DIR_UP);
      assign w_up_hit[gi]       = i_hall_up_req[gi] && w_up_sup;
      assign w_dn_hit[gi]       = i_hall_dn_req[gi] && w_dn_sup;
      assign w_hall_up_next[gi] = (r_hall_up[gi] || (i_hall_up_req[gi] && !w_up_sup))
                                  && !(w_clr_sel[gi] && i_clr_up);
      assign w_hall_dn_next[gi] = (r_hall_dn[gi] || (i_hall_dn_req[gi] && !w_dn_sup))
                                  && !(w_clr_sel[gi+1] && i_clr_dn);
    end
  endgenerate

  always_ff @(posedge clk10000hz or negedge reset) begin
    if (!reset) begin
      r_hall_up <= '0;
      r_hall_dn <= '0;
      r_car     <= '0;
    end else begin
      r_hall_up <= w_hall_up_next;
      r_hall_dn <= w_hall_dn_next;
      r_car     <= w_car_next;
    end
  end

  assign o_hall_up_lamp = r_hall_up;
  assign o_hall_dn_lamp = r_hall_dn;
  assign o_car_lamp     = r_car;
  assign o_absorb       = (|w_car_hit) || (|w_up_hit) || (|w_dn_hit);

endmodule

// File: rtl/elevator_call_scheduler.sv
// Four-floor elevator sequencer: picks a direction from pending lamps, hands
// one-floor steps to the motion unit and holds the door open at each stop.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES = DWELL_CYCLES_DEF
) (
  input  logic       clk10000hz,
  input  logic       reset,
  input  logic [2:0] hall_up_req,
  input  logic [2:0] hall_dn_req,
  input  logic [3:0] car_req,
  output logic       move_valid,
  output logic       move_up,
  input  logic       move_ready,
  input  logic       step_done,
  output logic [1:0] floor,
  output logic [1:0] dir,
  output logic       door_open,
  output logic [2:0] hall_up_lamp,
  output logic [2:0] hall_dn_lamp,
  output logic [3:0] car_lamp
);

  localparam logic [DWELL_CNT_W-1:0] DWELL_LAST = DWELL_CNT_W'(DWELL_CYCLES - 1);

  state_t                   r_state;
  logic [FLOOR_W-1:0]       r_floor;
  dir_t                     r_dir;
  logic                     r_door_open, r_move_valid, r_move_up;
  logic [DWELL_CNT_W-1:0]   r_dwell_cnt;

  logic [NUM_FLOORS-1:0]    w_lamp_f, w_up_f, w_dn_f;
  logic [FLOOR_W-1:0]       w_next_floor, w_clr_floor;
  logic                     w_here_cur, w_above_cur, w_below_cur;
  logic                     w_above_nxt, w_below_nxt, w_ahead_nxt;
  logic                     w_car_nxt, w_hall_dir_nxt, w_hall_oth_nxt;
  logic                     w_rev_nxt, w_stop_nxt, w_step_evt;
  logic                     w_clr_en, w_clr_up, w_clr_dn, w_absorb;
  dir_t                     w_flip_dir, w_end_dir;

  elevator_call_latch u_latch (
    .clk10000hz     (clk10000hz),
    .reset          (reset),
    .i_hall_up_req  (hall_up_req),
    .i_hall_dn_req  (hall_dn_req),
    .i_car_req      (car_req),
    .i_floor        (r_floor),
    .i_dir          (r_dir),
    .i_in_dwell     (r_state == S_DWELL),
    .i_clr_en       (w_clr_en),
    .i_clr_floor    (w_clr_floor),
    .i_clr_up       (w_clr_up),
    .i_clr_dn       (w_clr_dn),
    .o_hall_up_lamp (hall_up_lamp),
    .o_hall_dn_lamp (hall_dn_lamp),
    .o_car_lamp     (car_lamp),
    .o_absorb       (w_absorb)
  );

  assign w_up_f      = {1'b0, hall_up_lamp};
  assign w_dn_f      = {hall_dn_lamp, 1'b0};
  assign w_lamp_f    = car_lamp | w_up_f | w_dn_f;

  assign w_here_cur  = w_lamp_f[r_floor];
  assign w_above_cur = |(w_lamp_f & above_mask(r_floor));
  assign w_below_cur = |(w_lamp_f & below_mask(r_floor));

  assign w_next_floor = (r_dir == DIR_UP) ? r_floor + FLOOR_W'(1) : r_floor - FLOOR_W'(1);
  assign w_above_nxt  = |(w_lamp_f & above_mask(w_next_floor));
  assign w_below_nxt  = |(w_lamp_f & below_mask(w_next_floor));
  assign w_ahead_nxt  = (r_dir == DIR_UP) ? w_above_nxt : w_below_nxt;

  assign w_car_nxt      = car_lamp[w_next_floor];
  assign w_hall_dir_nxt = (r_dir == DIR_UP) ? w_up_f[w_next_floor] : w_dn_f[w_next_floor];
  assign w_hall_oth_nxt = (r_dir == DIR_UP) ? w_dn_f[w_next_floor] : w_up_f[w_next_floor];
  // Reversal: only an opposite-direction hall call here and nothing further on.
  assign w_rev_nxt      = !w_hall_dir_nxt && !w_ahead_nxt && w_hall_oth_nxt;
  assign w_stop_nxt     = w_car_nxt || w_hall_dir_nxt || w_rev_nxt;
  assign w_flip_dir     = (r_dir == DIR_UP) ? DIR_DN : DIR_UP;

  assign w_step_evt  = (r_state == S_MOVING) && step_done;
  assign w_clr_en    = ((r_state == S_IDLE) && w_here_cur) || (w_step_evt && w_stop_nxt);
  assign w_clr_floor = (r_state == S_MOVING) ? w_next_floor : r_floor;
  assign w_clr_up    = (r_state == S_IDLE) || w_rev_nxt || (r_dir == DIR_UP);
  assign w_clr_dn    = (r_state == S_IDLE) || w_rev_nxt || (r_dir == DIR_DN);

  // Keep going the current way if possible, otherwise turn round; idle prefers up.
  always_comb begin
    w_end_dir = DIR_IDLE;
    if (r_dir == DIR_DN) begin
      if (w_below_cur)      w_end_dir = DIR_DN;
      else if (w_above_cur) w_end_dir = DIR_UP;
    end else begin
      if (w_above_cur)      w_end_dir = DIR_UP;
      else if (w_below_cur) w_end_dir = DIR_DN;
    end
  end

  always_ff @(posedge clk10000hz or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_floor      <= '0;
      r_dir        <= DIR_IDLE;
      r_door_open  <= 1'b0;
      r_move_valid <= 1'b0;
      r_move_up    <= 1'b0;
      r_dwell_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_here_cur) begin
            r_state     <= S_DWELL;
            r_door_open <= 1'b1;
            r_dwell_cnt <= '0;
          end else if (w_above_cur || w_below_cur) begin
            r_state      <= S_MOVE_REQ;
            r_dir        <= w_above_cur ? DIR_UP : DIR_DN;
            r_move_valid <= 1'b1;
            r_move_up    <= w_above_cur;
          end
        end
        S_MOVE_REQ: begin
          if (move_ready) begin
            r_state      <= S_MOVING;
            r_move_valid <= 1'b0;
          end
        end
        S_MOVING: begin
          if (step_done) begin
            r_floor <= w_next_floor;
            if (w_stop_nxt) begin
              r_state     <= S_DWELL;
              r_door_open <= 1'b1;
              r_dwell_cnt <= '0;
              if (w_rev_nxt) r_dir <= w_flip_dir;
            end else if (w_ahead_nxt) begin
              r_state      <= S_MOVE_REQ;
              r_move_valid <= 1'b1;
              r_move_up    <= (r_dir == DIR_UP);
            end else begin
              r_state <= S_IDLE;
              r_dir   <= DIR_IDLE;
            end
          end
        end
        S_DWELL: begin
          if (w_absorb) begin
            r_dwell_cnt <= '0;
          end else if (r_dwell_cnt == DWELL_LAST) begin
            r_door_open <= 1'b0;
            r_dwell_cnt <= '0;
            r_dir       <= w_end_dir;
            if (w_end_dir == DIR_IDLE) begin
              r_state <= S_IDLE;
            end else begin
              r_state      <= S_MOVE_REQ;
              r_move_valid <= 1'b1;
              r_move_up    <= (w_end_dir == DIR_UP);
            end
          end else begin
            r_dwell_cnt <= r_dwell_cnt + DWELL_CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign floor      = r_floor;
  assign dir        = r_dir;
  assign door_open  = r_door_open;
  assign move_valid = r_move_valid;
  assign move_up    = r_move_up;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: a per-cycle vector table for the
// first trip plus hand-written multi-cycle sequences for dwell, reversal and reset.
module tb_elevator_call_scheduler;

  logic       clk10000hz = 1'b0;
  logic       reset;
  logic [2:0] hall_up_req, hall_dn_req;
  logic [3:0] car_req;
  logic       move_valid, move_up, move_ready, step_done;
  logic [1:0] floor, dir;
  logic       door_open;
  logic [2:0] hall_up_lamp, hall_dn_lamp;
  logic [3:0] car_lamp;

  int n_checks = 0;
  int n_errors = 0;

  elevator_call_scheduler dut (
    .clk10000hz   (clk10000hz),
    .reset        (reset),
    .hall_up_req  (hall_up_req),
    .hall_dn_req  (hall_dn_req),
    .car_req      (car_req),
    .move_valid   (move_valid),
    .move_up      (move_up),
    .move_ready   (move_ready),
    .step_done    (step_done),
    .floor        (floor),
    .dir          (dir),
    .door_open    (door_open),
    .hall_up_lamp (hall_up_lamp),
    .hall_dn_lamp (hall_dn_lamp),
    .car_lamp     (car_lamp)
  );

  always #5 clk10000hz = ~clk10000hz;

  typedef struct {
    logic [3:0] car;
    logic [2:0] hup;
    logic [2:0] hdn;
    logic       rdy;
    logic       done;
    logic [1:0] e_floor;
    logic [1:0] e_dir;
    logic       e_mv;
    logic       e_mu;
    logic       e_door;
    logic [3:0] e_cl;
    logic [2:0] e_hul;
    logic [2:0] e_hdl;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(negedge clk10000hz);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " floor"}, floor, 2'd0);
    chk({nm, " dir"}, dir, 2'b00);
    chk({nm, " door_open"}, door_open, 1'b0);
    chk({nm, " move_valid"}, move_valid, 1'b0);
    chk({nm, " move_up"}, move_up, 1'b0);
    chk({nm, " car_lamp"}, car_lamp, 4'b0);
    chk({nm, " hall_up_lamp"}, hall_up_lamp, 3'b0);
    chk({nm, " hall_dn_lamp"}, hall_dn_lamp, 3'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    car_req = '0; hall_up_req = '0; hall_dn_req = '0;
    move_ready = 1'b0; step_done = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  // One handshake: wait for the request, accept it, then finish the step.
  task automatic do_step(input logic exp_up, input logic [1:0] exp_floor, input string nm);
    int n = 0;
    while (!move_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " move_valid"}, move_valid, 1'b1);
    chk({nm, " move_up"}, move_up, exp_up);
    move_ready = 1'b1; tick(); move_ready = 1'b0;
    tick();
    step_done = 1'b1; tick(); step_done = 1'b0;
    chk({nm, " floor"}, floor, exp_floor);
  endtask

  task automatic wait_door_low(input int limit, input string nm);
    int n = 0;
    while (door_open && n < limit) begin
      tick();
      n++;
    end
    chk({nm, " door closed"}, door_open, 1'b0);
  endtask

  task automatic count_door(input int pulse_at, output int n);
    n = 0;
    while (door_open && n < 4000) begin
      n++;
      if (n == pulse_at) hall_up_req = 3'b010;
      tick();
      hall_up_req = 3'b000;
      if (n == pulse_at) chk("absorbed hall_up_lamp", hall_up_lamp, 3'b000);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic bad;

    //       car      hup     hdn     rdy   done  floor dir    mv    mu    door  cl       hul     hdl
    vecs[0] = '{4'b0010, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0010, 3'b000, 3'b000};
    vecs[1] = '{4'b0000, 3'b000, 3'b000, 1'b0, 1'b1, 2'd0, 2'b01, 1'b1, 1'b1, 1'b0, 4'b0010, 3'b000, 3'b000};
    vecs[2] = '{4'b0000, 3'b000, 3'b000, 1'b0, 1'b1, 2'd0, 2'b01, 1'b1, 1'b1, 1'b0, 4'b0010, 3'b000, 3'b000};
    vecs[3] = '{4'b0000, 3'b000, 3'b000, 1'b1, 1'b0, 2'd0, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0010, 3'b000, 3'b000};
    vecs[4] = '{4'b0000, 3'b000, 3'b000, 1'b1, 1'b0, 2'd0, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0010, 3'b000, 3'b000};
    vecs[5] = '{4'b0000, 3'b000, 3'b000, 1'b0, 1'b1, 2'd1, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000, 3'b000};
    vecs[6] = '{4'b0000, 3'b000, 3'b000, 1'b1, 1'b1, 2'd1, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000, 3'b000};
    vecs[7] = '{4'b0010, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000, 3'b000};
    vecs[8] = '{4'b0001, 3'b000, 3'b000, 1'b0, 1'b0, 2'd1, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0001, 3'b000, 3'b000};

    // Reset values, sampled while reset is still asserted.
    reset = 1'b0;
    car_req = '0; hall_up_req = '0; hall_dn_req = '0;
    move_ready = 1'b0; step_done = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset");
    reset = 1'b1;
    tick();

    // First trip, cycle by cycle, including ignored strobes and absorbed calls.
    for (int i = 0; i < 9; i++) begin
      car_req = vecs[i].car; hall_up_req = vecs[i].hup; hall_dn_req = vecs[i].hdn;
      move_ready = vecs[i].rdy; step_done = vecs[i].done;
      tick();
      car_req = '0; hall_up_req = '0; hall_dn_req = '0;
      move_ready = 1'b0; step_done = 1'b0;
      chk($sformatf("vec%0d floor", i), floor, vecs[i].e_floor);
      chk($sformatf("vec%0d dir", i), dir, vecs[i].e_dir);
      chk($sformatf("vec%0d move_valid", i), move_valid, vecs[i].e_mv);
      if (vecs[i].e_mv) chk($sformatf("vec%0d move_up", i), move_up, vecs[i].e_mu);
      chk($sformatf("vec%0d door_open", i), door_open, vecs[i].e_door);
      chk($sformatf("vec%0d car_lamp", i), car_lamp, vecs[i].e_cl);
      chk($sformatf("vec%0d hall_up_lamp", i), hall_up_lamp, vecs[i].e_hul);
      chk($sformatf("vec%0d hall_dn_lamp", i), hall_dn_lamp, vecs[i].e_hdl);
    end
    wait_door_low(2100, "behind");
    chk("behind dir", dir, 2'b10);
    chk("behind move_valid", move_valid, 1'b1);
    chk("behind move_up", move_up, 1'b0);

    // Motion unit stalls 50 cycles; a stray step_done must not move the car.
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step_done = (i == 25);
      tick();
      if (!move_valid || floor != 2'd1) bad = 1'b1;
    end
    step_done = 1'b0;
    chk("stall move_valid", move_valid, 1'b1);
    chk("stall floor", floor, 2'd1);
    chk("stall stable", bad, 1'b0);
    do_step(1'b0, 2'd0, "return");
    chk("return door_open", door_open, 1'b1);
    chk("return car_lamp", car_lamp, 4'b0);
    wait_door_low(2100, "return");
    chk("return dir idle", dir, 2'b00);

    // Top floor trip with exact dwell length.
    do_reset();
    car_req = 4'b1000; tick(); car_req = '0;
    tick();
    chk("top dir", dir, 2'b01);
    do_step(1'b1, 2'd1, "top1");
    do_step(1'b1, 2'd2, "top2");
    do_step(1'b1, 2'd3, "top3");
    chk("top door_open", door_open, 1'b1);
    count_door(0, n);
    chk("top dwell length", n, 2000);
    chk("top dir idle", dir, 2'b00);
    chk("top car_lamp", car_lamp, 4'b0);
    chk("top move_valid", move_valid, 1'b0);

    // Pass floor 1, serve floor 3, reverse and serve the down call at floor 1.
    do_reset();
    hall_dn_req = 3'b001; car_req = 4'b1000; tick();
    hall_dn_req = '0; car_req = '0;
    tick();
    chk("pass dir", dir, 2'b01);
    do_step(1'b1, 2'd1, "pass1");
    chk("pass1 door_open", door_open, 1'b0);
    chk("pass1 hall_dn_lamp", hall_dn_lamp, 3'b001);
    do_step(1'b1, 2'd2, "pass2");
    do_step(1'b1, 2'd3, "pass3");
    chk("pass3 door_open", door_open, 1'b1);
    wait_door_low(2100, "pass3");
    chk("pass3 reversed dir", dir, 2'b10);
    do_step(1'b0, 2'd2, "rev2");
    chk("rev2 door_open", door_open, 1'b0);
    do_step(1'b0, 2'd1, "rev1");
    chk("rev1 door_open", door_open, 1'b1);
    chk("rev1 hall_dn_lamp", hall_dn_lamp, 3'b000);
    wait_door_low(2100, "rev1");

    // Same-direction hall call at the open door restarts the dwell.
    do_reset();
    car_req = 4'b0010; tick(); car_req = '0;
    tick();
    do_step(1'b1, 2'd1, "absorb");
    chk("absorb door_open", door_open, 1'b1);
    count_door(1500, n);
    chk("absorb dwell length", n, 3500);
    chk("absorb hall_up_lamp end", hall_up_lamp, 3'b000);
    chk("absorb dir idle", dir, 2'b00);

    // Idle at floor 1 with calls both sides: up wins, then come back down.
    car_req = 4'b1001; tick(); car_req = '0;
    chk("both car_lamp", car_lamp, 4'b1001);
    tick();
    chk("both dir", dir, 2'b01);
    do_step(1'b1, 2'd2, "both2");
    do_step(1'b1, 2'd3, "both3");
    chk("both3 door_open", door_open, 1'b1);
    chk("both3 car_lamp", car_lamp, 4'b0001);
    wait_door_low(2100, "both3");
    chk("both3 dir", dir, 2'b10);
    do_step(1'b0, 2'd2, "down2");
    do_step(1'b0, 2'd1, "down1");
    chk("down1 door_open", door_open, 1'b0);
    do_step(1'b0, 2'd0, "down0");
    chk("down0 door_open", door_open, 1'b1);
    chk("down0 car_lamp", car_lamp, 4'b0000);
    wait_door_low(2100, "down0");
    chk("down0 dir idle", dir, 2'b00);

    // Reset asserted mid-move with lamps pending.
    do_reset();
    car_req = 4'b1000; hall_dn_req = 3'b010; tick();
    car_req = '0; hall_dn_req = '0;
    tick();
    do_step(1'b1, 2'd1, "mid1");
    do_step(1'b1, 2'd2, "mid2");
    chk("mid2 door_open", door_open, 1'b0);
    chk("mid2 lamps", {car_lamp, hall_dn_lamp}, {4'b1000, 3'b010});
    move_ready = 1'b1; tick(); move_ready = 1'b0;
    chk("mid moving move_valid", move_valid, 1'b0);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async reset");
    car_req = 4'b1111; step_done = 1'b1;
    tick(); tick();
    chk_reset_outputs("held reset");
    car_req = '0; step_done = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk_reset_outputs("after release");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
